// File: rtl/reg_file_pkg.sv
// Shared sizing and reset-value rule for the scoreboarded register file.
package reg_file_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;
    localparam int DATA_W   = 32;
    localparam int SB_CNT_W = 2;

    // Each register resets to its own index, zero-extended.
    function automatic logic [DATA_W-1:0] reset_value(input logic [REG_AW-1:0] idx);
        return {{(DATA_W-REG_AW){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/reg_file_sb_counter.sv
// sb_counter: saturating pending-write counter with synchronous clear and
// a one-cycle error pulse on overflow or underflow.
module sb_counter
    import reg_file_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    input  logic                dec,
    output logic [SB_CNT_W-1:0] cnt,
    output logic                err
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX  = {SB_CNT_W{1'b1}};
    localparam logic [SB_CNT_W-1:0] CNT_ZERO = {SB_CNT_W{1'b0}};
    localparam logic [SB_CNT_W-1:0] CNT_ONE  = SB_CNT_W'(1);

    logic [SB_CNT_W-1:0] cnt_q;
    logic [SB_CNT_W-1:0] cnt_d;

    // Next count; clear overrides any same-cycle inc/dec.
    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (inc && !dec) begin
            if (cnt_q == CNT_MAX) begin
                err = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (dec && !inc) begin
            if (cnt_q == CNT_ZERO) begin
                err = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 16x32 register file with per-register pending-write scoreboard.
// Optional macro WB_BYPASS_EN forwards the write-back value to the read ports.
module reg_file_sb
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    input  logic [REG_AW-1:0] WB_Dest,
    input  logic [DATA_W-1:0] WB_value,
    input  logic              WB_WB_en,
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic              flush,
    output logic              src1_busy,
    output logic              src2_busy,
    output logic              sb_err
);

    localparam logic [SB_CNT_W-1:0] CNT_ZERO = {SB_CNT_W{1'b0}};

    logic [DATA_W-1:0]                  regs_q [NUM_REGS];
    logic [DATA_W-1:0]                  regs_d [NUM_REGS];
    logic [NUM_REGS-1:0][SB_CNT_W-1:0]  cnt_s;
    logic [NUM_REGS-1:0]                err_s;
    logic                               sb_err_q;
    logic                               sb_err_d;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        sb_counter u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (flush),
            .inc (issue_en && (issue_dest == REG_AW'(r)) && !flush),
            .dec (WB_WB_en && (WB_Dest == REG_AW'(r))),
            .cnt (cnt_s[r]),
            .err (err_s[r])
        );
    end

    // Write-back port and sticky error accumulation.
    always_comb begin
        regs_d   = regs_q;
        sb_err_d = sb_err_q | (|err_s);
        if (WB_WB_en) begin
            regs_d[WB_Dest] = WB_value;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage and error flag; reset discards any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reset_value(REG_AW'(i));
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Combinational read ports and hazard flags.
    always_comb begin
        reg1      = regs_q[src1];
        reg2      = regs_q[src2];
        src1_busy = (cnt_s[src1] != CNT_ZERO);
        src2_busy = (cnt_s[src2] != CNT_ZERO);
`ifdef WB_BYPASS_EN
        // A retiring write to the last pending slot clears the hazard early.
        if (WB_WB_en && (WB_Dest == src1)) begin
            reg1      = WB_value;
            src1_busy = (cnt_s[src1] != CNT_ZERO) && (cnt_s[src1] != SB_CNT_W'(1));
        end else begin
            reg1      = regs_q[src1];
        end
        if (WB_WB_en && (WB_Dest == src2)) begin
            reg2      = WB_value;
            src2_busy = (cnt_s[src2] != CNT_ZERO) && (cnt_s[src2] != SB_CNT_W'(1));
        end else begin
            reg2      = regs_q[src2];
        end
`endif
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: behavioural model compared every cycle
// plus directed scenarios with literal expectations.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src1, src2, WB_Dest, issue_dest;
    logic [31:0] reg1, reg2, WB_value;
    logic        WB_WB_en, issue_en, flush;
    logic        src1_busy, src2_busy, sb_err;

    int total = 0;
    int bad   = 0;

    int          m_cnt [16];
    logic [31:0] m_reg [16];
    bit          m_err;
    bit          m_valid = 1'b0;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
        .WB_Dest(WB_Dest), .WB_value(WB_value), .WB_WB_en(WB_WB_en),
        .issue_en(issue_en), .issue_dest(issue_dest), .flush(flush),
        .src1_busy(src1_busy), .src2_busy(src2_busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    // Model: outstanding-write counts clamped to 0..3, any clamp is an error.
    always @(posedge clk) begin : model
        int n;
        bit e;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[i] <= 32'(i);
                m_cnt[i] <= 0;
            end
            m_err   <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            e = 1'b0;
            if (WB_WB_en) m_reg[WB_Dest] <= WB_value;
            for (int r = 0; r < 16; r++) begin
                if (flush) begin
                    m_cnt[r] <= 0;
                end else begin
                    n = m_cnt[r] + ((issue_en && issue_dest == 4'(r)) ? 1 : 0)
                                 - ((WB_WB_en && WB_Dest == 4'(r)) ? 1 : 0);
                    if (n > 3) begin n = 3; e = 1'b1; end
                    if (n < 0) begin n = 0; e = 1'b1; end
                    m_cnt[r] <= n;
                end
            end
            m_err <= m_err | e;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] s);
`ifdef WB_BYPASS_EN
        if (WB_WB_en && WB_Dest == s) return WB_value;
`endif
        return m_reg[s];
    endfunction

    function automatic logic exp_busy(input logic [3:0] s);
`ifdef WB_BYPASS_EN
        if (WB_WB_en && WB_Dest == s) return m_cnt[s] > 1;
`endif
        return m_cnt[s] != 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_reg1", reg1, exp_rd(src1));
            chk("model_reg2", reg2, exp_rd(src2));
            chk("model_busy1", 32'(src1_busy), 32'(exp_busy(src1)));
            chk("model_busy2", 32'(src2_busy), 32'(exp_busy(src2)));
            chk("model_err", 32'(sb_err), 32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; issue_en = 1'b0; WB_WB_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; issue_en = 1'b0; WB_WB_en = 1'b0; flush = 1'b0;
        src1 = 4'd0; src2 = 4'd0; WB_Dest = 4'd0; WB_value = 32'd0; issue_dest = 4'd0;
        cyc(); cyc();
        idle();

        // Reset values
        src1 = 4'd5; src2 = 4'd15; #1;
        chk("rst_reg1", reg1, 32'd5);
        chk("rst_reg2", reg2, 32'd15);
        chk("rst_busy1", 32'(src1_busy), 32'd0);
        chk("rst_busy2", 32'(src2_busy), 32'd0);
        chk("rst_err", 32'(sb_err), 32'd0);

        // Issue then retire reg 3
        issue_en = 1'b1; issue_dest = 4'd3; cyc();
        idle(); src1 = 4'd3; #1;
        chk("iss3_busy", 32'(src1_busy), 32'd1);
        WB_WB_en = 1'b1; WB_Dest = 4'd3; WB_value = 32'hDEADBEEF; #1;
`ifdef WB_BYPASS_EN
        chk("wb3_same_reg1", reg1, 32'hDEADBEEF);
        chk("wb3_same_busy", 32'(src1_busy), 32'd0);
`else
        chk("wb3_same_reg1", reg1, 32'd3);
        chk("wb3_same_busy", 32'(src1_busy), 32'd1);
`endif
        cyc(); idle(); #1;
        chk("wb3_next_reg1", reg1, 32'hDEADBEEF);
        chk("wb3_next_busy", 32'(src1_busy), 32'd0);

        // Simultaneous issue and write-back on reg 7
        issue_en = 1'b1; issue_dest = 4'd7; cyc();
        WB_WB_en = 1'b1; WB_Dest = 4'd7; WB_value = 32'h77; src1 = 4'd7; cyc();
        idle(); #1;
        chk("sim7_busy", 32'(src1_busy), 32'd1);
        WB_WB_en = 1'b1; WB_value = 32'h78; cyc();
        idle(); #1;
        chk("sim7_ret_busy", 32'(src1_busy), 32'd0);
        chk("sim7_ret_reg1", reg1, 32'h78);

        // Saturation on reg 2
        src1 = 4'd2; issue_en = 1'b1; issue_dest = 4'd2;
        cyc(); cyc(); cyc();
        chk("sat_err_before", 32'(sb_err), 32'd0);
        cyc(); idle(); #1;
        chk("sat_busy", 32'(src1_busy), 32'd1);
        chk("sat_err", 32'(sb_err), 32'd1);
        WB_WB_en = 1'b1; WB_Dest = 4'd2;
        for (int k = 0; k < 3; k++) begin
            WB_value = 32'hA0 + 32'(k); cyc();
        end
        idle(); #1;
        chk("drain_busy", 32'(src1_busy), 32'd0);
        WB_WB_en = 1'b1; WB_value = 32'hA3; cyc();
        idle(); #1;
        chk("under_busy", 32'(src1_busy), 32'd0);
        chk("under_err", 32'(sb_err), 32'd1);
        chk("under_reg1", reg1, 32'hA3);

        // Flush with same-cycle issue
        issue_en = 1'b1; issue_dest = 4'd1; cyc();
        issue_dest = 4'd4; cyc();
        idle(); src1 = 4'd1; src2 = 4'd4; #1;
        chk("pre_flush_busy1", 32'(src1_busy), 32'd1);
        chk("pre_flush_busy2", 32'(src2_busy), 32'd1);
        flush = 1'b1; issue_en = 1'b1; issue_dest = 4'd9; cyc();
        idle(); #1;
        chk("flush_busy1", 32'(src1_busy), 32'd0);
        chk("flush_busy2", 32'(src2_busy), 32'd0);
        src1 = 4'd9; #1;
        chk("flush_iss9", 32'(src1_busy), 32'd0);

        // Reset in the middle of activity
        issue_en = 1'b1; issue_dest = 4'd6; cyc();
        issue_dest = 4'd10; cyc();
        idle(); rst = 1'b1; WB_WB_en = 1'b1; WB_Dest = 4'd6; WB_value = 32'h1234; cyc();
        idle(); src1 = 4'd6; src2 = 4'd10; #1;
        chk("mid_rst_reg1", reg1, 32'd6);
        chk("mid_rst_reg2", reg2, 32'd10);
        chk("mid_rst_busy1", 32'(src1_busy), 32'd0);
        chk("mid_rst_busy2", 32'(src2_busy), 32'd0);
        chk("mid_rst_err", 32'(sb_err), 32'd0);

        // Mixed traffic checked by the model each cycle
        for (int i = 0; i < 40; i++) begin
            issue_en   = (i % 3) != 0;
            issue_dest = 4'(i % 5);
            WB_WB_en   = (i % 2) == 1 && i != 20;
            WB_Dest    = 4'((i + 3) % 5);
            WB_value   = 32'h1000 + 32'(i);
            flush      = (i == 20);
            src1       = 4'(i % 5);
            src2       = 4'((i + 3) % 5);
            cyc();
        end
        idle(); cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
